// File: rtl/div_writeback_queue.sv
// rtl/div_writeback_queue.sv - divider result capture and writeback FIFO
// Selects DIV/REM data per result, buffers it with its tag, drains under valid/ready.
module div_writeback_queue #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_op,
  input  logic [TAG_W-1:0]         in_rd,
  input  logic [DATA_W-1:0]        in_quotient,
  input  logic [DATA_W-1:0]        in_remainder,
  input  logic                     in_overflow,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [TAG_W-1:0]         wb_rd,
  output logic [DATA_W-1:0]        wb_data,
  output logic                     wb_exc,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              exc_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0]  rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  exc_mem;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             accept;
  logic             push;
  logic             pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = !full;
  assign wb_valid = (count != '0);

  // Writes to x0 complete the handshake but never occupy an entry.
  assign accept = in_valid & in_ready;
  assign push   = accept & (in_rd != '0);
  assign pop    = wb_valid & wb_ready;

  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      rd_mem[wr_ptr]   <= in_rd;
      data_mem[wr_ptr] <= in_op ? in_remainder : in_quotient;
      exc_mem[wr_ptr]  <= in_overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Overflow results are counted at the handshake, so discarded x0 writes still count.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_count <= '0;
    end else if (accept && in_overflow && (exc_count != 16'hFFFF)) begin
      exc_count <= exc_count + 16'd1;
    end
  end

  assign wb_rd   = wb_valid ? rd_mem[rd_ptr]   : '0;
  assign wb_data = wb_valid ? data_mem[rd_ptr] : '0;
  assign wb_exc  = wb_valid ? exc_mem[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_div_writeback_queue.sv
// tb/tb_div_writeback_queue.sv - bench for div_writeback_queue
// Directed scenarios plus random traffic checked against a queue-based model.
module tb_div_writeback_queue;

  localparam int DATA_W = 64;
  localparam int TAG_W  = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_op = 1'b0;
  logic [TAG_W-1:0]  in_rd = '0;
  logic [DATA_W-1:0] in_quotient = '0;
  logic [DATA_W-1:0] in_remainder = '0;
  logic              in_overflow = 1'b0;
  logic              wb_valid;
  logic              wb_ready = 1'b0;
  logic [TAG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_exc;
  logic [2:0]        count;
  logic [15:0]       exc_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [TAG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic              exc;
  } ent_t;

  ent_t mq[$];
  int   m_exc = 0;

  div_writeback_queue #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_quotient(in_quotient), .in_remainder(in_remainder), .in_overflow(in_overflow),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exc(wb_exc), .count(count), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a bounded FIFO of selected results and an overflow tally.
  task automatic model_step();
    bit acc, pp;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_exc = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      pp  = (mq.size() > 0) && wb_ready;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        if (in_overflow && m_exc < 65535) m_exc++;
        if (in_rd != 0) begin
          e.rd = in_rd;
          e.data = in_op ? in_remainder : in_quotient;
          e.exc = in_overflow;
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    ent_t h;
    h.rd = '0; h.data = '0; h.exc = 1'b0;
    if (mq.size() > 0) h = mq[0];
    chk({tag, ".count"},     64'(count),     64'(mq.size()));
    chk({tag, ".wb_valid"},  64'(wb_valid),  64'(mq.size() > 0));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < DEPTH));
    chk({tag, ".wb_rd"},     64'(wb_rd),     64'(h.rd));
    chk({tag, ".wb_data"},   wb_data,        h.data);
    chk({tag, ".wb_exc"},    64'(wb_exc),    64'(h.exc));
    chk({tag, ".exc_count"}, 64'(exc_count), 64'(m_exc));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input logic v, input logic op, input logic [TAG_W-1:0] rd,
                       input logic [63:0] q, input logic [63:0] r, input logic ovf);
    in_valid = v; in_op = op; in_rd = rd;
    in_quotient = q; in_remainder = r; in_overflow = ovf;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick("reset");
    rst = 1'b0;
    chk("reset.count_zero", 64'(count), 64'd0);

    // DIV 20 / -5
    drive(1, 0, 5'd7, -64'sd4, 64'd0, 0);
    tick("div");
    chk("div.data", wb_data, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("div.rd", 64'(wb_rd), 64'd7);
    drive(0, 0, 0, 0, 0, 0);
    wb_ready = 1'b1;
    tick("div_drain");

    // REM -24878735 / -879357
    drive(1, 1, 5'd3, 64'd28, -64'sd256739, 0);
    wb_ready = 1'b0;
    tick("rem");
    chk("rem.data", wb_data, -64'sd256739);
    drive(0, 0, 0, 0, 0, 0);
    wb_ready = 1'b1;
    tick("rem_drain");

    // Fill to DEPTH, reject a fifth, then drain in order and re-fill past wrap
    wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 5'(i), 64'(i * 100), 64'(i), 0);
      tick("fill");
    end
    chk("fill.full_ready", 64'(in_ready), 64'd0);
    drive(1, 0, 5'd5, 64'd500, 64'd5, 1);
    wb_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain.order", 64'(wb_rd), 64'(i));
      tick("drain");
      drive(0, 0, 0, 0, 0, 0);
    end
    chk("drain.empty", 64'(wb_valid), 64'd0);
    wb_ready = 1'b0;
    for (int i = 9; i <= 12; i++) begin
      drive(1, 1, 5'(i), 64'd0, 64'(i * 3), i[0]);
      tick("refill");
    end
    drive(0, 0, 0, 0, 0, 0);
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick("refill_drain");

    // Push and pop together at count 2
    wb_ready = 1'b0;
    drive(1, 0, 5'd20, 64'd1, 64'd0, 0); tick("pp_a");
    drive(1, 0, 5'd21, 64'd2, 64'd0, 0); tick("pp_b");
    wb_ready = 1'b1;
    drive(1, 0, 5'd22, 64'd3, 64'd0, 0); tick("pp_both");
    chk("pp.count", 64'(count), 64'd2);
    chk("pp.head", 64'(wb_rd), 64'd21);
    drive(0, 0, 0, 0, 0, 0);
    tick("pp_drain1"); tick("pp_drain2");

    // Write to x0 with overflow
    rst = 1'b1; tick("rst2"); rst = 1'b0;
    drive(1, 0, 5'd0, 64'd9, 64'd9, 1);
    tick("x0");
    chk("x0.exc_count", 64'(exc_count), 64'd1);
    chk("x0.wb_valid", 64'(wb_valid), 64'd0);
    drive(0, 0, 0, 0, 0, 0);

    // Flush at count 3
    wb_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 5'(i + 4), 64'(i), 64'd0, 1);
      tick("pre_flush");
    end
    drive(0, 0, 0, 0, 0, 0);
    flush = 1'b1; wb_ready = 1'b1;
    tick("flush");
    flush = 1'b0;
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.exc_kept", 64'(exc_count), 64'd4);

    // Reset mid-drain
    wb_ready = 1'b0;
    drive(1, 1, 5'd17, 64'd1, 64'hDEAD, 1); tick("pre_rst");
    drive(1, 0, 5'd18, 64'hBEEF, 64'd1, 0); tick("pre_rst");
    drive(0, 0, 0, 0, 0, 0);
    wb_ready = 1'b1;
    tick("mid_drain");
    rst = 1'b1; tick("rst_mid"); rst = 1'b0;
    chk("rst_mid.wb_data", wb_data, 64'd0);
    chk("rst_mid.exc", 64'(exc_count), 64'd0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 7) == 0);
      wb_ready = $urandom_range(0, 2) != 0;
      flush = 1'b0;
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) begin
        flush = 1'b1;
        in_valid = 1'b0;
      end
      tick("rand");
    end
    rst = 1'b0; flush = 1'b0;

    // exc_count saturation
    drive(1, 0, 5'd0, 64'd0, 64'd0, 1);
    wb_ready = 1'b1;
    for (int n = 0; n < 65540; n++) begin
      model_step();
      @(posedge clk);
    end
    #1;
    compare_all("sat");
    chk("sat.exc_count", 64'(exc_count), 64'hFFFF);
    drive(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
